if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the rv64 core pipeline; sits directly upstream of the IF/ID register and decode. Owns the PC and issues in-order word requests to instruction memory with up to two outstanding requests. Buffers returned instructions with their PCs in a small FIFO. Honours downstream back-pressure, including the hazard unit's load-use stall, and branch/jump redirects from EX, discarding responses to killed requests.

## Interface
- RESET_PC, 64'h0000_0000_8000_0000: PC loaded on reset.
- FIFO_DEPTH, 4: instruction buffer entries; power of two, ≥2.
- MAX_OUTSTANDING, 2: maximum granted-but-unreturned imem requests.
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- redirect_i  in  1  EX redirect (taken branch/jump/trap).
- redirect_pc_i  in  64  redirect target.
- imem_req_o  out  1  fetch request valid.
- imem_addr_o  out  64  request address (word aligned).
- imem_gnt_i  in  1  request accepted this cycle (req & gnt = handshake).
- imem_rvalid_i  in  1  response valid; responses return in order, ≥1 cycle after grant.
- imem_rdata_i  in  32  response instruction word.
- if_valid_o  out  1  FIFO head valid.
- if_pc_o  out  64  PC of head.
- if_instr_o  out  32  instruction of head.
- if_fault_o  out  1  head is an instruction-address-misaligned fault.
- if_ready_i  in  1  downstream accepts head; driven low by the load-use stall.

## Operation
- State: pc_q (next fetch address), out_cnt (granted, not returned), drop_cnt (responses to discard), FIFO of {pc, instr, fault}.
- Issue: imem_req_o = !rst_i & !redirect_i & !halt_q & out_cnt < MAX_OUTSTANDING & (out_cnt + occupancy) < FIFO_DEPTH. imem_addr_o = pc_q. On req & gnt: pc_q += 4; the request's PC is pushed into an in-flight PC queue (depth MAX_OUTSTANDING).
- Response: on imem_rvalid_i with drop_cnt == 0, push {inflight PC, rdata, 0} into the FIFO and decrement out_cnt. With drop_cnt > 0, discard the response and decrement both counters.
- Grant and response in the same cycle: out_cnt is unchanged.
- Pop: if_valid_o & if_ready_i removes the head. Push and pop in the same cycle are both allowed, including when the FIFO is full.
- Redirect (highest priority, overrides pop/push/issue):
  - pc_q <= redirect_pc_i.
  - FIFO and in-flight PC queue flushed.
  - drop_cnt <= out_cnt minus any response returning this cycle.
  - No request is issued in the redirect cycle.
- pc_q arithmetic is modulo 2^64; wrap from 64'hFFFF_FFFF_FFFF_FFFC to 0 is silent.
- Outputs come from the FIFO head only; they are don't-care when if_valid_o=0.

## Timing
- Reset (synchronous): pc_q=RESET_PC, out_cnt=0, drop_cnt=0, FIFO empty, halt_q=0, imem_req_o=0, if_valid_o=0, if_fault_o=0. Reset mid-transaction abandons in-flight responses; the memory is reset concurrently.
- First request in the first cycle after rst_i deasserts.
- Latency: grant at T, rvalid at T+1 (earliest), if_valid_o at T+2. There is no rdata-to-output bypass.
- Steady state with a 1-cycle memory and if_ready_i=1: one instruction per cycle.
- if_ready_i low holds the head stable. Fetching continues until the FIFO plus outstanding requests reach FIFO_DEPTH.
- Redirect at T: the first request to the target is issued at T+1; if_valid_o=0 at T+1.

## Configuration
- IF_MISALIGN_TRAP_EN defined:
  - A redirect target with bits [1:0] != 0 sets halt_q. No requests are issued.
  - One FIFO entry {redirect_pc_i, 32'h0000_0013, fault=1} is pushed once the FIFO is empty.
  - halt_q clears only on the next redirect.
- Undefined: redirect_pc_i[1:0] is forced to 0, and if_fault_o is tied to 0.

## Structure
- Shared package core_pkg holds:
  - NOP_INSTR = 32'h0000_0013.
  - Typedef fetch_entry_t {pc[63:0], instr[31:0], fault}.
  - RESET_PC default constant.
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t, parameterised depth. Ports push/pop/flush/full/empty/count; simultaneous push+pop when full is legal.

## Test plan
- Reset release, 1-cycle memory, ready=1: requests at 0x8000_0000, 0x…04, 0x…08 on consecutive cycles; if_valid_o high from cycle 3 with matching PCs and no bubbles.
- if_ready_i=0 for 10 cycles: at most FIFO_DEPTH outstanding + buffered. Head PC is held. After release, instructions drain in order with no loss or duplication.
- Redirect to 0x8000_1000 while 2 requests are outstanding: both late responses are discarded. The next valid output has PC 0x8000_1000.
- Memory with 3-cycle response plus grant stalls: imem_req_o never exceeds 2 outstanding; output PCs stay strictly +4 sequential.
- Redirect and rvalid in the same cycle with FIFO full and if_ready_i=1: the FIFO is empty the next cycle and drop_cnt accounts correctly.
- IF_MISALIGN_TRAP_EN, redirect to 0x8000_0002: exactly one output with if_fault_o=1, PC 0x8000_0002, instr 0x00000013; no imem requests until the next redirect.

Source files
------------

// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
//   Shared constants and types for the rv64 core front end.
//   - RESET_PC_DEFAULT : default PC loaded on reset
//   - NOP_INSTR        : canonical NOP (addi x0, x0, 0)
//   - fetch_entry_t    : one instruction-buffer entry {pc, instr, fault}
// -----------------------------------------------------------------------------
package core_pkg;

  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        fault;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
//   Synchronous FIFO of fetch_entry_t used as the fetch instruction buffer.
//   Ports:
//     clk_i, rst_i  : clock, synchronous active-high reset
//     flush_i       : empties the FIFO (takes priority over push/pop)
//     push_i        : write push_data_i at the tail
//     push_data_i   : entry to write
//     pop_i         : remove the head (ignored when empty)
//     head_o        : current head entry (don't-care when empty_o)
//     full_o        : no free entry
//     empty_o       : no valid entry
//     count_o       : number of valid entries (0..DEPTH)
//   Handshake: an entry is written when push_i is high and there is room, where
//   a pop in the same cycle frees room, so push+pop while full is legal.
//   DEPTH must be a power of two, at least 2.
// -----------------------------------------------------------------------------
module fetch_fifo
  import core_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  output fetch_entry_t head_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [CW-1:0] count_o
);

  fetch_entry_t    mem_q [DEPTH];
  logic [AW-1:0]   wr_q, rd_q;
  logic [CW-1:0]   count_q;
  logic            do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= push_data_i;
  end

endmodule

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
//   Instruction-fetch stage. Owns the PC, issues in-order word requests to
//   instruction memory (up to MAX_OUTSTANDING in flight), buffers returned
//   words with their PCs in fetch_fifo and presents the head downstream.
//   Redirects from EX flush everything and discard responses to killed
//   requests.
//
//   Build option: IF_MISALIGN_TRAP_EN
//     defined   : a redirect target with [1:0] != 0 halts fetch and delivers a
//                 single {target, NOP, fault=1} entry; the next redirect
//                 resumes fetch.
//     undefined : redirect target bits [1:0] are forced to zero and
//                 if_fault_o is always 0.
//
//   Ports:
//     clk_i, rst_i             : clock, synchronous active-high reset
//     redirect_i/redirect_pc_i : EX redirect and its target
//     imem_req_o/imem_addr_o   : fetch request, word address (= pc_q)
//     imem_gnt_i               : request accepted (req & gnt = handshake)
//     imem_rvalid_i/rdata_i    : in-order response, >= 1 cycle after grant
//     if_valid_o/pc_o/instr_o/fault_o : FIFO head towards decode
//     if_ready_i               : downstream takes the head (load-use stall
//                                drives it low)
//   Handshakes: imem side transfers on req & gnt; downstream transfers on
//   if_valid_o & if_ready_i. Neither valid depends on its ready.
// -----------------------------------------------------------------------------
module if_stage
  import core_pkg::*;
#(
  parameter logic [63:0] RESET_PC        = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        redirect_i,
  input  logic [63:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [63:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  output logic [63:0] if_pc_o,
  output logic [31:0] if_instr_o,
  output logic        if_fault_o,
  input  logic        if_ready_i
);

  localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam int SW  = $clog2(FIFO_DEPTH + MAX_OUTSTANDING + 1);
  localparam int IW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

`ifdef IF_MISALIGN_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  logic [63:0]   pc_q, pc_d;
  logic [OW-1:0] out_cnt_q, out_cnt_d;
  logic [OW-1:0] drop_cnt_q, drop_cnt_d;
  logic          halt_q, halt_d;
  logic          fault_pend_q, fault_pend_d;

  // PCs of granted, still-live requests, in issue order.
  logic [63:0]   infl_pc_q [MAX_OUTSTANDING];
  logic [IW-1:0] infl_wr_q, infl_wr_d, infl_rd_q, infl_rd_d;

  logic          misalign;
  logic [63:0]   redirect_tgt;
  logic          grant, resp_keep, resp_drop, fault_push;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FCW-1:0] fifo_count;
  fetch_entry_t  fifo_wdata, fifo_head;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
    return (idx == IW'(MAX_OUTSTANDING - 1)) ? '0 : idx + IW'(1);
  endfunction

  assign misalign     = TRAP_EN & (redirect_pc_i[1:0] != 2'b00);
  assign redirect_tgt = TRAP_EN ? redirect_pc_i : {redirect_pc_i[63:2], 2'b00};

  // Credit check: outstanding responses already own a FIFO slot, so the sum
  // of outstanding and buffered entries never exceeds FIFO_DEPTH.
  assign imem_req_o  = ~rst_i & ~redirect_i & ~halt_q
                     & (out_cnt_q < OW'(MAX_OUTSTANDING))
                     & ((SW'(out_cnt_q) + SW'(fifo_count)) < SW'(FIFO_DEPTH));
  assign imem_addr_o = pc_q;

  assign grant     = imem_req_o & imem_gnt_i;
  assign resp_keep = imem_rvalid_i & (drop_cnt_q == '0);
  assign resp_drop = imem_rvalid_i & (drop_cnt_q != '0);

  // While a fault is pending no live request exists, so the fault entry never
  // competes with a kept response for the push port.
  assign fault_push = fault_pend_q & fifo_empty & ~redirect_i;
  assign fifo_push  = ~redirect_i & (resp_keep | fault_push);
  assign fifo_pop   = if_valid_o & if_ready_i & ~redirect_i;

  always_comb begin
    fifo_wdata = '0;
    if (fault_push) begin
      fifo_wdata.pc    = pc_q;
      fifo_wdata.instr = NOP_INSTR;
      fifo_wdata.fault = 1'b1;
    end else begin
      fifo_wdata.pc    = infl_pc_q[infl_rd_q];
      fifo_wdata.instr = imem_rdata_i;
      fifo_wdata.fault = 1'b0;
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (redirect_i),
    .push_i      (fifo_push),
    .push_data_i (fifo_wdata),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign if_valid_o = ~fifo_empty;
  assign if_pc_o    = fifo_head.pc;
  assign if_instr_o = fifo_head.instr;
  assign if_fault_o = TRAP_EN & fifo_head.fault;

  // Redirect overrides everything. out_cnt still tracks killed requests; they
  // are moved into drop_cnt so their responses get swallowed on return.
  always_comb begin
    pc_d         = pc_q;
    out_cnt_d    = out_cnt_q + OW'(grant) - OW'(imem_rvalid_i);
    drop_cnt_d   = drop_cnt_q - OW'(resp_drop);
    halt_d       = halt_q;
    fault_pend_d = fault_pend_q & ~fault_push;
    infl_wr_d    = grant     ? next_idx(infl_wr_q) : infl_wr_q;
    infl_rd_d    = resp_keep ? next_idx(infl_rd_q) : infl_rd_q;
    if (redirect_i) begin
      pc_d         = redirect_tgt;
      drop_cnt_d   = out_cnt_q - OW'(imem_rvalid_i);
      halt_d       = misalign;
      fault_pend_d = misalign;
      infl_wr_d    = '0;
      infl_rd_d    = '0;
    end else if (grant) begin
      pc_d = pc_q + 64'd4;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q         <= RESET_PC;
      out_cnt_q    <= '0;
      drop_cnt_q   <= '0;
      halt_q       <= 1'b0;
      fault_pend_q <= 1'b0;
      infl_wr_q    <= '0;
      infl_rd_q    <= '0;
    end else begin
      pc_q         <= pc_d;
      out_cnt_q    <= out_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      halt_q       <= halt_d;
      fault_pend_q <= fault_pend_d;
      infl_wr_q    <= infl_wr_d;
      infl_rd_q    <= infl_rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (grant) infl_pc_q[infl_wr_q] <= pc_q;
  end

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage
//   Bench for if_stage. Contains a behavioural memory (in-order responses with
//   random latency and random grant stalls) and a reference model of the
//   fetch stage built from queues: expected PCs in the buffer, requests in
//   flight, and the next fetch address. Compares on every cycle.
//   Honours IF_MISALIGN_TRAP_EN like the design.
// -----------------------------------------------------------------------------
module tb_if_stage;
  import core_pkg::*;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  // ---------------- clock / reset ----------------
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        redirect_i = 1'b0;
  logic [63:0] redirect_pc_i = '0;
  logic        imem_req_o;
  logic [63:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        if_valid_o;
  logic [63:0] if_pc_o;
  logic [31:0] if_instr_o;
  logic        if_fault_o;
  logic        if_ready_i = 1'b0;

  always #5 clk_i = ~clk_i;

  if_stage #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .if_valid_o    (if_valid_o),
    .if_pc_o       (if_pc_o),
    .if_instr_o    (if_instr_o),
    .if_fault_o    (if_fault_o),
    .if_ready_i    (if_ready_i)
  );

  // ---------------- reference model state ----------------
  typedef struct {
    logic [63:0] addr;
    int          rdy;
    logic        stale;
  } mreq_t;

  mreq_t       mem_q[$];    // granted, not yet returned (memory side)
  logic [63:0] exp_q[$];    // PCs the instruction buffer must hold, in order
  logic [63:0] fetch_pc;
  bit          halted, fault_pend, fault_head, model_ok;
  int          cyc;
  int          n_cmp, n_err, n_pops;

  // knobs
  int          gnt_pct, rdy_pct, lat_min, lat_max, redir_pm;
  bit          rst_drv, redir_once, redir_on_rv;
  logic [63:0] redir_target;

  // observations for hand-computed checks
  logic        s_req, s_valid, s_fault;
  logic [63:0] s_addr, s_pc;
  logic [31:0] s_instr;
  bit          saw_zero, track_first, first_pop_seen;
  logic [63:0] first_pop_pc;
  int          fault_pops;
  logic [63:0] fault_pop_pc;
  logic [31:0] fault_pop_instr;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [63:0] rand_target();
    logic [63:0] t;
    case ($urandom_range(3))
      0:       t = RST_PC + 64'({$urandom_range(255), 2'b00});
      1:       t = 64'hFFFF_FFFF_FFFF_FF00 + 64'({$urandom_range(63), 2'b00});
      2:       t = {$urandom, $urandom} & ~64'h3;
      default: t = RST_PC + 64'($urandom_range(63));
    endcase
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h expected=%h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver + compare + model update, one cycle ----------------
  task automatic step();
    bit          rv, red, exp_req, hs, pop, was_empty;
    logic [63:0] tgt;
    mreq_t       m;
    int          lat;
    @(negedge clk_i);
    rv  = !rst_drv && (mem_q.size() > 0) && (mem_q[0].rdy <= cyc);
    red = 1'b0;
    tgt = rand_target();
    if (!rst_drv) begin
      if (redir_once || (redir_on_rv && rv)) begin
        red = 1'b1; tgt = redir_target; redir_once = 0; redir_on_rv = 0;
      end else if ($urandom_range(999) < redir_pm) begin
        red = 1'b1;
      end
    end
    rst_i         = rst_drv;
    imem_rvalid_i = rv;
    imem_rdata_i  = rv ? mem_word(mem_q[0].addr) : 32'($urandom);
    imem_gnt_i    = ($urandom_range(99) < gnt_pct);
    if_ready_i    = ($urandom_range(99) < rdy_pct);
    redirect_i    = red;
    redirect_pc_i = red ? tgt : {$urandom, $urandom};
    #1;
    exp_req = !rst_drv && !red && !halted && (mem_q.size() < MAXO)
              && ((mem_q.size() + exp_q.size()) < DEPTH);
    if (model_ok) begin
      check("req", imem_req_o, exp_req);
      if (exp_req) check("addr", imem_addr_o, fetch_pc);
      check("valid", if_valid_o, exp_q.size() > 0);
      if (exp_q.size() > 0) begin
        check("pc", if_pc_o, exp_q[0]);
        if (fault_head) begin
          check("instr_fault", if_instr_o, NOP_INSTR);
          check("fault_flag", if_fault_o, 1);
        end else begin
          check("instr", if_instr_o, mem_word(exp_q[0]));
          check("fault_flag", if_fault_o, 0);
        end
      end
`ifndef IF_MISALIGN_TRAP_EN
      check("fault_tied", if_fault_o, 0);
`endif
    end
    s_req = imem_req_o; s_addr = imem_addr_o; s_valid = if_valid_o;
    s_pc = if_pc_o; s_instr = if_instr_o; s_fault = if_fault_o;
    hs  = exp_req && imem_gnt_i;
    pop = (exp_q.size() > 0) && if_ready_i && !red;
    @(posedge clk_i);
    if (rst_drv) begin
      mem_q.delete(); exp_q.delete();
      fetch_pc = RST_PC; halted = 0; fault_pend = 0; fault_head = 0;
      model_ok = 1;
    end else if (red) begin
      if (rv) void'(mem_q.pop_front());
      foreach (mem_q[i]) mem_q[i].stale = 1'b1;
      exp_q.delete();
      fault_head = 0;
`ifdef IF_MISALIGN_TRAP_EN
      halted     = (tgt[1:0] != 2'b00);
      fault_pend = halted;
      fetch_pc   = tgt;
`else
      fetch_pc   = {tgt[63:2], 2'b00};
`endif
    end else begin
      was_empty = (exp_q.size() == 0);
      if (pop) begin
        void'(exp_q.pop_front());
        n_pops++;
        if (track_first) begin
          first_pop_pc = s_pc; first_pop_seen = 1; track_first = 0;
        end
        if (fault_head) begin
          fault_pops++; fault_pop_pc = s_pc; fault_pop_instr = s_instr;
          fault_head = 0;
        end
      end
      if (rv) begin
        m = mem_q.pop_front();
        if (!m.stale) exp_q.push_back(m.addr);
      end
      if (fault_pend && was_empty) begin
        exp_q.push_back(fetch_pc); fault_head = 1; fault_pend = 0;
      end
      if (hs) begin
        lat = $urandom_range(lat_max, lat_min);
        mem_q.push_back('{addr: fetch_pc, rdy: cyc + lat, stale: 1'b0});
        if (fetch_pc == 64'h0) saw_zero = 1;
        fetch_pc = fetch_pc + 64'd4;
      end
    end
    cyc++;
  endtask

  task automatic set_mem(input int g, input int r, input int lmin, input int lmax);
    gnt_pct = g; rdy_pct = r; lat_min = lmin; lat_max = lmax;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_cmp = 0; n_err = 0; n_pops = 0; cyc = 0; model_ok = 0;
    redir_pm = 0; redir_once = 0; redir_on_rv = 0; redir_target = '0;
    saw_zero = 0; track_first = 0; first_pop_seen = 0; fault_pops = 0;
    first_pop_pc = '0; fault_pop_pc = '0; fault_pop_instr = '0;
    fetch_pc = RST_PC; halted = 0; fault_pend = 0; fault_head = 0;
    set_mem(100, 100, 1, 1);
    rst_drv = 1;
    repeat (3) step();
    check("rst_req", s_req, 0);
    check("rst_valid", s_valid, 0);
    check("rst_fault", s_fault, 0);

    // Back-to-back fetch with a 1-cycle memory
    rst_drv = 0;
    step();
    check("c1_req", s_req, 1);
    check("c1_addr", s_addr, 64'h8000_0000);
    step();
    check("c2_addr", s_addr, 64'h8000_0004);
    check("c2_valid", s_valid, 0);
    step();
    check("c3_addr", s_addr, 64'h8000_0008);
    check("c3_valid", s_valid, 1);
    check("c3_pc", s_pc, 64'h8000_0000);
    step();
    check("c4_valid", s_valid, 1);
    check("c4_pc", s_pc, 64'h8000_0004);

    // Downstream stall for 10 cycles
    rdy_pct = 0;
    repeat (10) step();
    check("stall_valid", s_valid, 1);
    check("stall_pc", s_pc, 64'h8000_0008);
    rdy_pct = 100;
    repeat (20) step();

    // Redirect while two slow requests are outstanding
    set_mem(100, 100, 3, 3);
    for (int i = 0; i < 20 && mem_q.size() != 2; i++) step();
    check("two_outstanding", 64'(mem_q.size()), 2);
    redir_target = 64'h8000_1000; redir_once = 1;
    track_first = 1; first_pop_seen = 0;
    step();
    step();
    check("redir_t1_valid", s_valid, 0);
    for (int i = 0; i < 40 && !first_pop_seen; i++) step();
    check("redir_first_seen", first_pop_seen, 1);
    check("redir_first_pc", first_pop_pc, 64'h8000_1000);

    // Redirect in steady state: the target is requested the very next cycle
    set_mem(100, 100, 1, 1);
    repeat (10) step();
    redir_target = 64'h8000_2000; redir_once = 1;
    step();
    step();
    check("redir_next_req", s_req, 1);
    check("redir_next_addr", s_addr, 64'h8000_2000);
    check("redir_next_valid", s_valid, 0);

    // Redirect landing on a response while the buffer is nearly full
    set_mem(100, 0, 3, 3);
    repeat (12) step();
    rdy_pct = 100;
    redir_target = 64'h8000_3000; redir_on_rv = 1;
    for (int i = 0; i < 30 && redir_on_rv; i++) step();
    check("rv_redir_hit", redir_on_rv, 0);
    step();
    check("rv_redir_valid", s_valid, 0);

    // PC wrap-around
    set_mem(100, 100, 1, 1);
    saw_zero = 0;
    redir_target = 64'hFFFF_FFFF_FFFF_FFF8; redir_once = 1;
    repeat (10) step();
    check("wrap_zero_req", saw_zero, 1);

    // Misaligned redirect target
`ifdef IF_MISALIGN_TRAP_EN
    fault_pops = 0;
    redir_target = 64'h8000_0002; redir_once = 1;
    repeat (15) step();
    check("trap_count", 64'(fault_pops), 1);
    check("trap_pc", fault_pop_pc, 64'h8000_0002);
    check("trap_instr", fault_pop_instr, 64'h13);
    check("trap_no_req", s_req, 0);
    redir_target = 64'h8000_0100;
`else
    redir_target = 64'h8000_0102;
`endif
    redir_once = 1; track_first = 1; first_pop_seen = 0;
    for (int i = 0; i < 30 && (redir_once || !first_pop_seen); i++) step();
    check("align_first_pc", first_pop_pc, 64'h8000_0100);

    // Randomised traffic
    for (int blk = 0; blk < 12; blk++) begin
      lat_min = $urandom_range(3, 1);
      set_mem($urandom_range(100, 30), $urandom_range(100, 20), lat_min,
              lat_min + $urandom_range(4));
      redir_pm = $urandom_range(30);
      repeat (250) step();
    end
    redir_pm = 0;

    // Reset in the middle of traffic
    rst_drv = 1;
    step();
    step();
    check("mid_rst_req", s_req, 0);
    check("mid_rst_valid", s_valid, 0);
    rst_drv = 0;
    set_mem(100, 100, 1, 1);
    step();
    check("post_rst_req", s_req, 1);
    check("post_rst_addr", s_addr, RST_PC);
    repeat (20) step();

    check("liveness", n_pops > 500, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: actual=running expected=finished cycle=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
